// File: rtl/otter_pkg.sv
// Shared OTTER front-end types: PC-source encoding, fetch FSM states, reset vector.
package otter_pkg;

  typedef enum logic [3:0] {
    PC_SEQ    = 4'd0,
    PC_JALR   = 4'd1,
    PC_BRANCH = 4'd2,
    PC_JAL    = 4'd3
  } pcsource_t;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  // Encodings 4..15 behave like sequential fetch, so only 1..3 redirect.
  function automatic logic is_redirect(input logic [3:0] src);
    return (src == PC_JALR) || (src == PC_BRANCH) || (src == PC_JAL);
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Instruction-memory request/response channel: valid/ready requests, in-order responses.
interface fetch_redirect_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;

  modport master (output req_valid, req_addr, input req_ready, rsp_valid);
  modport slave  (input req_valid, req_addr, output req_ready, rsp_valid);
endinterface

// File: rtl/fetch_pc_fifo.sv
// Small FIFO of fetch PCs, one entry per outstanding IMEM request; push and pop may coincide.
module fetch_pc_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg < CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch sequencer: owns the PC, issues IMEM requests, applies EX redirects,
// flushes IF/ID and ID/EX and drops wrong-path responses still in flight.
module fetch_redirect_ctrl
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          MAX_OUT      = 2,
  parameter int          CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  input  logic [3:0]           ex_pcsource,
  input  logic [31:0]          ex_target,
  input  logic                 stall,
  fetch_redirect_ctrl_if.master imem,
  output logic                 fetch_valid,
  output logic [31:0]          fetch_pc,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 if_id_stall,
  output logic [CNT_W-1:0]     redirect_cnt
);

  localparam int OW = $clog2(MAX_OUT + 1);

  fetch_state_t      state_reg;
  fetch_state_t      state_next;
  logic [31:0]       pc_reg;
  logic [31:0]       tgt_reg;
  logic [OW-1:0]     disc_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [OW-1:0]     outst;
  logic [31:0]       fifo_head;
  logic              red;
  logic              fire;
  logic              rsp;
  logic              slot_free;
  logic              discard;

  // The PC FIFO holds exactly one entry per outstanding request, so its
  // occupancy doubles as the outstanding-request counter.
  fetch_pc_fifo #(
    .DEPTH (MAX_OUT),
    .W     (32)
  ) u_pc_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fire),
    .push_data (imem.req_addr),
    .pop       (rsp),
    .head      (fifo_head),
    .count     (outst)
  );

  assign rsp       = imem.rsp_valid;
  assign slot_free = outst < OW'(MAX_OUT);
  assign red       = rst_n && ex_valid && is_redirect(ex_pcsource) && (state_reg == RUN);
  assign fire      = imem.req_valid && imem.req_ready;

  // Outputs are held low while reset is asserted, independent of inputs.
  assign imem.req_addr  = (state_reg == REDIRECT) ? tgt_reg : pc_reg;
  assign imem.req_valid = rst_n && slot_free &&
                          ((state_reg == REDIRECT) || (!stall && !red));

  assign discard      = (disc_reg != '0) || red;
  assign fetch_valid  = rst_n && rsp && !discard;
  assign fetch_pc     = fetch_valid ? fifo_head : 32'h0;
  assign if_id_flush  = red;
  assign id_ex_flush  = red;
  assign if_id_stall  = rst_n && stall && !red;
  assign redirect_cnt = cnt_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:      if (red)  state_next = REDIRECT;
      REDIRECT: if (fire) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      pc_reg    <= RESET_VECTOR;
      tgt_reg   <= RESET_VECTOR;
      disc_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      // req_addr is PC in RUN and TGT in REDIRECT, so both cases advance past it.
      if (fire) pc_reg <= imem.req_addr + 32'd4;
      if (red)  tgt_reg <= {ex_target[31:2], 2'b00};
      // A response landing in the redirect cycle is dropped right now, so it
      // is not counted again in the discard load.
      if (red) begin
        disc_reg <= outst - OW'(rsp);
      end else if (rsp && (disc_reg != '0)) begin
        disc_reg <= disc_reg - 1'b1;
      end
      if (red && (cnt_reg != '1)) cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Sequences the instruction-fetch side of the pipelined OTTER core. Owns the PC register and issues fetch requests to instruction memory over a valid/ready request channel with in-order responses.
- Applies redirects produced by the EX-stage branch/jump resolution (CU_PCSOURCE encoding).
- Generates the IF/ID and ID/EX flushes and discards wrong-path fetch responses still in flight.
- Sits between the PC/IMEM interface and the IF/ID pipeline register.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- MAX_OUT, 2, maximum outstanding fetch requests (1..7).
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- CLK  in  1  core clock.
- RST_N  in  1  asynchronous active-low reset.
- EX_VALID  in  1  EX stage holds a valid instruction.
- EX_PCSOURCE  in  4  0=PC+4, 1=JALR, 2=taken branch, 3=JAL; 4..15 treated as 0.
- EX_TARGET  in  32  redirect target from EX.
- STALL  in  1  load-use / decode stall request.
- IMEM_REQ_VALID  out  1  fetch request valid.
- IMEM_REQ_READY  in  1  IMEM accepts request.
- IMEM_REQ_ADDR  out  32  fetch address.
- IMEM_RSP_VALID  in  1  fetch response (in order, one per accepted request).
- FETCH_VALID  out  1  response is correct-path; write it into IF/ID.
- FETCH_PC  out  32  PC of the response, from an internal PC FIFO of depth MAX_OUT.
- IF_ID_FLUSH  out  1  squash IF/ID.
- ID_EX_FLUSH  out  1  squash ID/EX.
- IF_ID_STALL  out  1  hold IF/ID.
- REDIRECT_CNT  out  CNT_W  redirects taken, saturating.

Behaviour:
- Reset (async, RST_N=0):
  - PC=RESET_VECTOR, state=RUN, OUTST=0, DISC=0, PC FIFO empty, REDIRECT_CNT=0.
  - All 1-bit outputs 0; IMEM_REQ_ADDR=RESET_VECTOR; FETCH_PC=0.
  - Reset mid-operation drops all state. Responses after reset release are ignored only if DISC says so. DISC is 0, so IMEM must also be reset.
- Redirect event: RED = EX_VALID && EX_PCSOURCE in {1,2,3} && state==RUN.
- Request fire: FIRE = IMEM_REQ_VALID && IMEM_REQ_READY.
- OUTST (outstanding counter): +1 on FIRE, -1 on IMEM_RSP_VALID, unchanged when both occur.
- State RUN:
  - IMEM_REQ_ADDR=PC.
  - IMEM_REQ_VALID = !STALL && !RED && OUTST<MAX_OUT.
  - On FIRE: PC<=PC+4 and the PC is pushed to the PC FIFO.
- RED cycle (combinational, same cycle):
  - IF_ID_FLUSH=1, ID_EX_FLUSH=1, IMEM_REQ_VALID=0.
  - Latch TGT = {EX_TARGET[31:2],2'b00}.
  - DISC <= OUTST - IMEM_RSP_VALID.
  - REDIRECT_CNT++ (saturating).
  - Next state REDIRECT.
- RED has priority over STALL. IF_ID_STALL = STALL && !RED.
- State REDIRECT:
  - IMEM_REQ_VALID=1 regardless of STALL; IMEM_REQ_ADDR=TGT.
  - On FIRE: PC<=TGT+4, TGT pushed to the PC FIFO, state->RUN.
  - Requires OUTST<MAX_OUT; otherwise hold until a response frees a slot.
  - EX redirects are ignored, since EX is flushed. A bench assertion checks that none occur.
- Response handling, each IMEM_RSP_VALID:
  - The PC FIFO is popped.
  - If DISC>0 or RED is active this cycle: the response is discarded, FETCH_VALID=0, and DISC-- (only when DISC>0).
  - Otherwise FETCH_VALID=1 and FETCH_PC = popped entry.
- A response in the RED cycle is wrong-path. It is excluded from the DISC load, which is why DISC is loaded with OUTST-1 in that case.
- The downstream IF/ID must accept FETCH_VALID unconditionally. It provides a MAX_OUT-deep skid buffer.
- Back-to-back redirects (second RED while DISC>0): DISC reloads with the current OUTST-rsp, which covers all older wrong-path entries.
- PC wraps modulo 2^32; no wrap detection.
- Latency: redirect-to-target request is 1 cycle when IMEM_REQ_READY=1. The first correct-path FETCH_VALID follows the target response.

Decomposition:
- Shared package (otter_pkg) holds:
  - pcsource_t enum: PC_SEQ=0, PC_JALR=1, PC_BRANCH=2, PC_JAL=3.
  - fetch_state_t enum: RUN, REDIRECT.
  - RESET_VECTOR default constant.
  - The branch-condition generator also imports pcsource_t.
- One sub-module: fetch_pc_fifo (synchronous FIFO, depth MAX_OUT, 32-bit, push/pop/count, simultaneous push+pop allowed, async active-low reset).

Test Plan:
- Reset release, READY=1, RSP returning 1 cycle later: requests at 0x0,0x4,0x8 → FETCH_VALID with FETCH_PC 0x0,0x4,0x8 in order; OUTST never exceeds 2.
- EX_PCSOURCE=3, EX_TARGET=0x100 with 2 outstanding (0x8,0xC): flushes both high 1 cycle; both responses discarded; next request addr 0x100; FETCH_PC 0x100 then 0x104; REDIRECT_CNT=1.
- JALR to 0x203 → request addr 0x200.
- Redirect in same cycle as STALL=1 and a response arrival: IF_ID_STALL=0, response discarded, DISC=OUTST-1.
- Redirect while IMEM_REQ_READY=0 for 3 cycles: IMEM_REQ_VALID held with addr=TGT; PC unchanged until FIRE.
- STALL=1 for 4 cycles in RUN: no requests, IF_ID_STALL=1, in-flight responses still delivered with FETCH_VALID=1.
- Second redirect (0x300) while DISC=1 after first redirect: all older responses dropped; first correct FETCH_PC=0x300.
- RST_N low mid-REDIRECT: immediate return to PC=RESET_VECTOR, state RUN, counters 0.
